// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and a
// constant-width helper for sizing the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2; returns at least 1 so a 1-bit counter still exists.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell evaluated once per cycle by the serial controller.
module full_adder (
  output logic cout,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder evaluation per clock, LSB first,
// with the carry looped back through a register.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a, sh_b, sum_sh;
  logic             carry;
  logic             fa_s, fa_c;
  logic             last;

  full_adder u_fa (
    .cout (fa_c),
    .s    (fa_s),
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (start) begin
          sh_a   <= a;
          sh_b   <= b;
          carry  <= cin;
          cnt    <= '0;
          sum_sh <= '0;
        end
        ST_RUN: begin
          // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_c;
          sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
          cnt    <= last ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        busy      = 1'b1;
        state_nxt = last ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // carry holds the final carry-out once RUN completes, until the next accept.
  assign sum  = sum_sh;
  assign cout = carry;

endmodule
